spram_ctrl: RTL and testbench

Request-side controller for the single-port RAM (`spram`). It accepts valid/ready read and write requests from a client, drives the RAM's `addr`/`din`/`wen` port, and returns read data on a valid/ready response channel. A small bypass buffer absorbs the RAM's one-cycle read latency under response backpressure. With the optional init feature, it also clears the whole RAM after reset.

---
 rtl/spram_pkg.sv | 23 ++
 rtl/spram_rsp_buf.sv | 47 ++++
 rtl/spram_ctrl.sv | 122 ++++++++++++
 tb/tb_spram_ctrl.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/spram_pkg.sv
// Shared types and sizing for the single-port RAM request controller.
package spram_pkg;

  // Controller phases: clear sweep after reset, then normal request service.
  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // Response buffer entries behind the RAM's one-cycle read latency.
  localparam int RSP_BUF_DEPTH = 2;

  // Occupancy spans 0..RSP_BUF_DEPTH+1 (buffered plus one inflight read).
  localparam int OCC_W = $clog2(RSP_BUF_DEPTH + 2);

  localparam int BUF_PTR_W = (RSP_BUF_DEPTH > 1) ? $clog2(RSP_BUF_DEPTH) : 1;

  // Circular pointer advance for the response buffer.
  function automatic logic [BUF_PTR_W-1:0] ptr_inc(input logic [BUF_PTR_W-1:0] p);
    return (p == BUF_PTR_W'(RSP_BUF_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

endpackage

// File: rtl/spram_rsp_buf.sv
// Small response FIFO. When empty, head shows push_data directly so the
// parent can forward RAM read data in the same cycle it appears.
import spram_pkg::*;

module spram_rsp_buf #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic [OCC_W-1:0]      count,
  output logic [DATA_WIDTH-1:0] head
);

  logic [RSP_BUF_DEPTH-1:0][DATA_WIDTH-1:0] mem;
  logic [BUF_PTR_W-1:0]                     wr_ptr;
  logic [BUF_PTR_W-1:0]                     rd_ptr;

  // Storage, pointers and count; a simultaneous push and pop leaves count unchanged.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      mem    <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ptr_inc(wr_ptr);
      end
      if (pop) rd_ptr <= ptr_inc(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Empty-bypass head select.
  always_comb begin
    head = (count == '0) ? push_data : mem[rd_ptr];
  end

endmodule

// File: rtl/spram_ctrl.sv
// Request-side controller for the single-port RAM: valid/ready requests in,
// RAM port drive out, read data back on a valid/ready response channel.
// Optional post-reset clear sweep enabled by defining SPRAM_CTRL_INIT_EN.
import spram_pkg::*;

module spram_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int WORD_DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [WORD_DEPTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic [WORD_DEPTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_din,
  output logic                  ram_wen,
  input  logic [DATA_WIDTH-1:0] ram_dout,
  output logic                  init_done
);

  state_t                state;
  state_t                state_nxt;
  logic                  inflight;
  logic                  run;
  logic                  buf_empty;
  logic                  push;
  logic                  pop;
  logic [OCC_W-1:0]      buf_count;
  logic [OCC_W-1:0]      occupancy;
  logic [DATA_WIDTH-1:0] buf_head;

`ifdef SPRAM_CTRL_INIT_EN
  localparam logic [WORD_DEPTH-1:0] INIT_LAST = '1;

  logic [WORD_DEPTH-1:0] init_cnt;

  // State register and sweep address counter; counter moves only while sweeping.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state    <= ST_INIT;
      init_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (state == ST_INIT) init_cnt <= init_cnt + 1'b1;
    end
  end

  // Leave the sweep after the last address has been written.
  always_comb begin
    state_nxt = state;
    if (state == ST_INIT && init_cnt == INIT_LAST) state_nxt = ST_RUN;
  end

  assign init_done = (state == ST_RUN);
`else
  // State register; without the sweep the controller is always running.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= ST_RUN;
    else         state <= state_nxt;
  end

  // No transitions exist in this build.
  always_comb begin
    state_nxt = state;
  end

  assign init_done = 1'b1;
`endif

  // One read can be in the RAM pipe; it lands on ram_dout the next cycle.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) inflight <= 1'b0;
    else         inflight <= req_valid && req_ready && !req_we;
  end

  // Request acceptance and RAM port drive. Readiness depends only on
  // registered occupancy, never on rsp_ready; resetn masks it while held.
  always_comb begin
    occupancy = buf_count + OCC_W'(inflight);
    run       = (state == ST_RUN) && resetn;
    req_ready = run && (occupancy < OCC_W'(RSP_BUF_DEPTH));
    ram_addr  = req_addr;
    ram_din   = req_wdata;
    ram_wen   = req_valid && req_ready && req_we;
`ifdef SPRAM_CTRL_INIT_EN
    if (state == ST_INIT) begin
      ram_addr = init_cnt;
      ram_din  = '0;
      ram_wen  = resetn;
    end
`endif
  end

  // Response side: forward RAM data when the buffer is empty, otherwise
  // serve the buffer head; inflight data is parked unless taken right away.
  always_comb begin
    buf_empty = (buf_count == '0);
    rsp_valid = !buf_empty || inflight;
    rsp_rdata = rsp_valid ? buf_head : '0;
    pop       = rsp_ready && !buf_empty;
    push      = inflight && !(buf_empty && rsp_ready);
  end

  spram_rsp_buf #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_rsp_buf (
    .clk      (clk),
    .resetn   (resetn),
    .push     (push),
    .push_data(ram_dout),
    .pop      (pop),
    .count    (buf_count),
    .head     (buf_head)
  );

endmodule

// File: tb/tb_spram_ctrl.sv
// Bench for spram_ctrl with a behavioural single-port RAM alongside.
// Honours SPRAM_CTRL_INIT_EN the same way as the design.
module tb_spram_ctrl;

  localparam int DW    = 32;
  localparam int AW    = 2;
  localparam int DEPTH = 1 << AW;
`ifdef SPRAM_CTRL_INIT_EN
  localparam bit INIT_EN = 1'b1;
`else
  localparam bit INIT_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          resetn;
  logic          req_valid, req_ready, req_we;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic          rsp_valid, rsp_ready;
  logic [DW-1:0] rsp_rdata;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_din;
  logic          ram_wen;
  logic [DW-1:0] ram_dout = '0;
  logic          init_done;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  spram_ctrl #(.DATA_WIDTH(DW), .WORD_DEPTH(AW)) dut (
    .clk(clk), .resetn(resetn),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .ram_addr(ram_addr), .ram_din(ram_din), .ram_wen(ram_wen),
    .ram_dout(ram_dout), .init_done(init_done)
  );

  // RAM: write when wen, otherwise dout follows the addressed word.
  logic [DW-1:0] ram [0:DEPTH-1] = '{default: '0};
  always @(posedge clk) begin
    if (ram_wen) ram[ram_addr] <= ram_din;
    else         ram_dout      <= ram[ram_addr];
  end

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Model: memory contents, queue of reads owed to the client in order,
  // and the log of responses the client actually took.
  logic [DW-1:0] mdl [0:DEPTH-1] = '{default: '0};
  logic [DW-1:0] owed [$];
  logic [DW-1:0] got  [$];
  int            k = 0;   // cycles since reset release

  always @(negedge clk) begin
    if (!resetn) begin
      owed.delete();
      k = 0;
      chk("sb_rst_req_ready", req_ready, 0);
      chk("sb_rst_rsp_valid", rsp_valid, 0);
      chk("sb_rst_ram_wen",   ram_wen,   0);
      chk("sb_rst_init_done", init_done, DW'(!INIT_EN));
    end else begin
      if (INIT_EN && k < DEPTH) begin
        chk("sb_init_wen",       ram_wen,   1);
        chk("sb_init_addr",      ram_addr,  DW'(k));
        chk("sb_init_din",       ram_din,   0);
        chk("sb_init_req_ready", req_ready, 0);
        chk("sb_init_rsp_valid", rsp_valid, 0);
        chk("sb_init_done_lo",   init_done, 0);
        mdl[k] = '0;
      end else begin
        logic exp_ready;
        exp_ready = (owed.size() < 2);
        chk("sb_init_done",  init_done, 1);
        chk("sb_req_ready",  req_ready, DW'(exp_ready));
        chk("sb_ram_wen",    ram_wen,   DW'(req_valid && exp_ready && req_we));
        chk("sb_rsp_valid",  rsp_valid, DW'(owed.size() > 0));
        if (owed.size() > 0) chk("sb_rsp_rdata", rsp_rdata, owed[0]);
        if (rsp_valid && rsp_ready && owed.size() > 0) begin
          got.push_back(rsp_rdata);
          void'(owed.pop_front());
        end
        if (req_valid && exp_ready) begin
          if (req_we) mdl[req_addr] = req_wdata;
          else        owed.push_back(mdl[req_addr]);
        end
      end
      if (k < 1000) k++;
    end
  end

  function automatic logic [DW-1:0] got_at(input int i);
    return (i < got.size()) ? got[i] : 32'hxxxx_xxxx;
  endfunction

  // Present one request and hold it until accepted (bounded).
  task automatic issue(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                       output int waits);
    waits     = 0;
    req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = d;
    @(negedge clk);
    while (!req_ready && waits < 20) begin
      @(posedge clk); #1;
      @(negedge clk);
      waits++;
    end
    if (!req_ready) begin
      n_cmp++; n_err++;
      $display("FAIL issue_timeout: req_ready stayed 0 for addr %0d", a);
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    req_valid = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int w;
    resetn = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
    rsp_ready = 1'b1;
    repeat (2) @(posedge clk); #1;
    @(negedge clk);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_rdata", rsp_rdata, 0);
    chk("rst_ram_wen",   ram_wen,   0);
    chk("rst_ram_addr",  ram_addr,  0);
    chk("rst_ram_din",   ram_din,   0);
    chk("rst_init_done", init_done, INIT_EN ? 32'd0 : 32'd1);
    @(posedge clk); #1;
    resetn = 1'b1;

`ifdef SPRAM_CTRL_INIT_EN
    for (int i = 0; i < DEPTH; i++) begin
      @(negedge clk);
      chk("init_wen",  ram_wen,   1);
      chk("init_addr", ram_addr,  DW'(i));
      chk("init_din",  ram_din,   0);
      chk("init_lo",   init_done, 0);
      @(posedge clk); #1;
    end
    @(negedge clk);
    chk("init_done_c5", init_done, 1);
    chk("init_ready_c5", req_ready, 1);
    @(posedge clk); #1;
`endif

    // Cleared (or never written) word reads back zero.
    got.delete();
    issue(1'b0, 2'd2, '0, w);
    idle(3);
    chk("rd2_count", DW'(got.size()), 1);
    chk("rd2_data",  got_at(0), 32'h0000_0000);

    // Write then read the same address on the next cycle.
    issue(1'b1, 2'd1, 32'hDEAD_BEEF, w);
    issue(1'b0, 2'd1, '0, w);
    @(negedge clk);
    chk("wr_rd_valid", rsp_valid, 1);
    chk("wr_rd_data",  rsp_rdata, 32'hDEAD_BEEF);
    @(posedge clk); #1;
    idle(2);

    // Streaming reads, one per cycle.
    for (int i = 0; i < DEPTH; i++) issue(1'b1, AW'(i), DW'((i + 1) * 16), w);
    got.delete();
    for (int i = 0; i < DEPTH; i++) begin
      issue(1'b0, AW'(i), '0, w);
      chk("stream_no_stall", DW'(w), 0);
    end
    idle(3);
    chk("stream_count", DW'(got.size()), 4);
    chk("stream_0", got_at(0), 32'h10);
    chk("stream_1", got_at(1), 32'h20);
    chk("stream_2", got_at(2), 32'h30);
    chk("stream_3", got_at(3), 32'h40);

    // Backpressure: two reads fit, the third stalls until a pop.
    got.delete();
    rsp_ready = 1'b0;
    issue(1'b0, 2'd0, '0, w);
    chk("bp_first_waits", DW'(w), 0);
    issue(1'b0, 2'd1, '0, w);
    chk("bp_second_waits", DW'(w), 0);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 2'd2;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("bp_third_blocked", req_ready, 0);
      chk("bp_hold_valid",    rsp_valid, 1);
      chk("bp_hold_data",     rsp_rdata, 32'h10);
      @(posedge clk); #1;
    end
    rsp_ready = 1'b1;
    issue(1'b0, 2'd2, '0, w);
    chk("bp_third_waits", DW'(w), 1);
    idle(3);
    chk("bp_count", DW'(got.size()), 3);
    chk("bp_0", got_at(0), 32'h10);
    chk("bp_1", got_at(1), 32'h20);
    chk("bp_2", got_at(2), 32'h30);

    // Read then write the same word: old data first, new data afterwards.
    got.delete();
    issue(1'b0, 2'd3, '0, w);
    issue(1'b1, 2'd3, 32'h99, w);
    issue(1'b0, 2'd3, '0, w);
    idle(3);
    chk("rbw_count", DW'(got.size()), 2);
    chk("rbw_old",   got_at(0), 32'h40);
    chk("rbw_new",   got_at(1), 32'h99);

    // Reset with two responses buffered drops them.
    got.delete();
    rsp_ready = 1'b0;
    issue(1'b0, 2'd0, '0, w);
    issue(1'b0, 2'd1, '0, w);
    idle(1);
    chk("mid_pre_valid", rsp_valid, 1);
    resetn = 1'b0;
    #1;
    chk("mid_rst_valid", rsp_valid, 0);
    chk("mid_rst_ready", req_ready, 0);
    repeat (2) @(posedge clk); #1;
    resetn    = 1'b1;
    rsp_ready = 1'b1;
    idle(INIT_EN ? DEPTH + 3 : 3);
    chk("mid_no_stale", DW'(got.size()), 0);
    issue(1'b0, 2'd0, '0, w);
    idle(3);
    chk("mid_after_count", DW'(got.size()), 1);
    chk("mid_after_data",  got_at(0), INIT_EN ? 32'h0 : 32'h10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
